mcu_ctrl_tmo: RTL and testbench

//  Parametrised main control unit for the multi-cycle RV32I core: sequences fetch/exec/load/store like the MCU.

---
 rtl/mcu_ctrl_tmo.sv | 190 +++++++++++++++++++
 tb/tb_mcu_ctrl_tmo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_ctrl_tmo.sv
// Main control unit for the multi-cycle RV32I core: fetch/exec/load/store sequencing
// with handshake timeouts, illegal-opcode trapping and a retired-instruction counter.
module mcu_ctrl_tmo #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8,
    parameter int CNT_W          = 32,
    parameter bit CHECK_ILLEGAL  = 1'b1
) (
    input  logic             MCU_Clk,
    input  logic             MCU_Reset,
    input  logic             MCU_Insmem_Valid,
    input  logic             MCU_Datamem_Valid_In,
    input  logic             MCU_Datamem_Ready_In,
    input  logic [6:0]       MCU_Opcode_InBUS,
    input  logic             MCU_Trap_Clear,
    output logic [2:0]       MCU_Internal_State,
    output logic             MCU_Pc_Reset,
    output logic             MCU_Enpc_Set,
    output logic             MCU_Enpc_Reset,
    output logic             MCU_Ir_Reset,
    output logic             MCU_Ir_Set,
    output logic             MCU_RegFile_Reset,
    output logic             MCU_Insmem_Ready,
    output logic             MCU_Datamem_Ready_Out,
    output logic             MCU_Datamem_Valid_Out,
    output logic             MCU_Trap,
    output logic [1:0]       MCU_Trap_Cause,
    output logic [CNT_W-1:0] MCU_Retired
);

    typedef enum logic [2:0] {
        S_RESET      = 3'b000,
        S_WAIT       = 3'b001,
        S_FETCH      = 3'b010,
        S_EXEC       = 3'b011,
        S_WAIT_VALID = 3'b100,
        S_WAIT_READY = 3'b101,
        S_TRAP       = 3'b110
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_INS_TMO  = 2'b10;
    localparam logic [1:0] CAUSE_DATA_TMO = 2'b11;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e             r_state;
    state_e             w_next;
    logic [TMO_W-1:0]   r_tmo;
    logic [1:0]         r_cause;
    logic [1:0]         w_trap_cause;
    logic [CNT_W-1:0]   r_retired;
    logic               w_tmo_expired;
    logic               w_in_wait;

    assign w_tmo_expired = TMO_EN && (r_tmo == TMO_LAST);
    assign w_in_wait     = (r_state == S_WAIT) || (r_state == S_WAIT_VALID) ||
                           (r_state == S_WAIT_READY);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MCU_Clk or negedge MCU_Reset) begin
        if (!MCU_Reset) r_state <= S_RESET;
        else            r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next       = S_RESET;
        w_trap_cause = CAUSE_NONE;
        case (r_state)
            S_RESET: w_next = S_WAIT;
            S_WAIT: begin
                if (MCU_Insmem_Valid) begin
                    w_next = S_FETCH;
                end else if (w_tmo_expired) begin
                    w_next       = S_TRAP;
                    w_trap_cause = CAUSE_INS_TMO;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_FETCH: begin
                case (MCU_Opcode_InBUS)
                    OP_LOAD:  w_next = S_WAIT_VALID;
                    OP_STORE: w_next = S_WAIT_READY;
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                    OP_IMM, OP_REG, OP_MISC_MEM, OP_SYSTEM: w_next = S_EXEC;
                    default: begin
                        if (CHECK_ILLEGAL) begin
                            w_next       = S_TRAP;
                            w_trap_cause = CAUSE_ILLEGAL;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                endcase
            end
            S_EXEC: w_next = S_WAIT;
            S_WAIT_VALID, S_WAIT_READY: begin
                // A handshake arriving on the last allowed cycle still wins over the timeout.
                if ((r_state == S_WAIT_VALID) ? MCU_Datamem_Valid_In : MCU_Datamem_Ready_In) begin
                    w_next = S_EXEC;
                end else if (w_tmo_expired) begin
                    w_next       = S_TRAP;
                    w_trap_cause = CAUSE_DATA_TMO;
                end else begin
                    w_next = r_state;
                end
            end
            S_TRAP:  w_next = MCU_Trap_Clear ? S_RESET : S_TRAP;
            default: w_next = S_RESET;
        endcase
    end

    always_comb begin
        MCU_Pc_Reset          = 1'b0;
        MCU_Enpc_Set          = 1'b0;
        MCU_Enpc_Reset        = 1'b0;
        MCU_Ir_Reset          = 1'b0;
        MCU_Ir_Set            = 1'b0;
        MCU_RegFile_Reset     = 1'b0;
        MCU_Insmem_Ready      = 1'b0;
        MCU_Datamem_Ready_Out = 1'b0;
        MCU_Datamem_Valid_Out = 1'b0;
        MCU_Trap              = 1'b0;
        case (r_state)
            S_WAIT: begin
                MCU_Enpc_Reset   = 1'b1;
                MCU_Insmem_Ready = 1'b1;
            end
            S_FETCH: begin
                MCU_Enpc_Reset = 1'b1;
                MCU_Ir_Set     = 1'b1;
            end
            S_EXEC: begin
                MCU_Enpc_Set   = 1'b1;
                MCU_Enpc_Reset = 1'b1;
            end
            S_WAIT_VALID: MCU_Datamem_Ready_Out = 1'b1;
            S_WAIT_READY: MCU_Datamem_Valid_Out = 1'b1;
            S_TRAP:       MCU_Trap              = 1'b1;
            default: begin
                // RESET and the unused 111 encoding share the reset decode.
                MCU_Pc_Reset      = 1'b1;
                MCU_Ir_Reset      = 1'b1;
                MCU_RegFile_Reset = 1'b1;
            end
        endcase
    end

    always_ff @(posedge MCU_Clk or negedge MCU_Reset) begin
        if (!MCU_Reset) begin
            r_tmo     <= '0;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            if (w_next != r_state) r_tmo <= '0;
            else if (w_in_wait)    r_tmo <= r_tmo + TMO_W'(1);

            // Cause latches on TRAP entry and survives until software clears the trap.
            if (r_state == S_TRAP) begin
                if (MCU_Trap_Clear) r_cause <= CAUSE_NONE;
            end else if (w_next == S_TRAP) begin
                r_cause <= w_trap_cause;
            end

            if (r_state == S_EXEC) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign MCU_Internal_State = r_state;
    assign MCU_Trap_Cause     = r_cause;
    assign MCU_Retired        = r_retired;

endmodule

// File: tb/tb_mcu_ctrl_tmo.sv
// Directed bench for mcu_ctrl_tmo: a cycle table on a short-timeout, 4-bit-counter
// instance plus hand sequences for counter wrap, async reset and a no-timeout instance.
module tb_mcu_ctrl_tmo;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] RST = 3'd0, WT = 3'd1, FE = 3'd2, EX = 3'd3,
                           WV  = 3'd4, WR = 3'd5, TR = 3'd6;

    typedef struct {
        logic [2:0] st;
        logic [1:0] cause;
        logic [3:0] ret;
        logic       insv;
        logic [6:0] op;
        logic       dval;
        logic       drdy;
        logic       clr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: TIMEOUT_CYCLES=4, CNT_W=4, illegal opcodes trap
    logic       rst_a, insv_a, dval_a, drdy_a, clr_a;
    logic [6:0] op_a;
    logic [2:0] st_a;
    logic [1:0] cause_a;
    logic [3:0] ret_a;
    logic       pcr_a, eps_a, epr_a, irr_a, irs_a, rfr_a, insr_a, dro_a, dvo_a, trap_a;
    logic [9:0] ctrl_a;
    assign ctrl_a = {pcr_a, eps_a, epr_a, irr_a, irs_a, rfr_a, insr_a, dro_a, dvo_a, trap_a};

    mcu_ctrl_tmo #(.TIMEOUT_CYCLES(4), .TMO_W(3), .CNT_W(4), .CHECK_ILLEGAL(1'b1)) dut_a (
        .MCU_Clk(clk), .MCU_Reset(rst_a),
        .MCU_Insmem_Valid(insv_a), .MCU_Datamem_Valid_In(dval_a),
        .MCU_Datamem_Ready_In(drdy_a), .MCU_Opcode_InBUS(op_a), .MCU_Trap_Clear(clr_a),
        .MCU_Internal_State(st_a), .MCU_Pc_Reset(pcr_a), .MCU_Enpc_Set(eps_a),
        .MCU_Enpc_Reset(epr_a), .MCU_Ir_Reset(irr_a), .MCU_Ir_Set(irs_a),
        .MCU_RegFile_Reset(rfr_a), .MCU_Insmem_Ready(insr_a),
        .MCU_Datamem_Ready_Out(dro_a), .MCU_Datamem_Valid_Out(dvo_a),
        .MCU_Trap(trap_a), .MCU_Trap_Cause(cause_a), .MCU_Retired(ret_a)
    );

    // Instance B: timeout disabled, illegal opcodes execute
    logic        rst_b, insv_b, dval_b, drdy_b, clr_b;
    logic [6:0]  op_b;
    logic [2:0]  st_b;
    logic [1:0]  cause_b;
    logic [31:0] ret_b;
    logic        pcr_b, eps_b, epr_b, irr_b, irs_b, rfr_b, insr_b, dro_b, dvo_b, trap_b;
    logic [9:0]  ctrl_b;
    assign ctrl_b = {pcr_b, eps_b, epr_b, irr_b, irs_b, rfr_b, insr_b, dro_b, dvo_b, trap_b};

    mcu_ctrl_tmo #(.TIMEOUT_CYCLES(0), .TMO_W(8), .CNT_W(32), .CHECK_ILLEGAL(1'b0)) dut_b (
        .MCU_Clk(clk), .MCU_Reset(rst_b),
        .MCU_Insmem_Valid(insv_b), .MCU_Datamem_Valid_In(dval_b),
        .MCU_Datamem_Ready_In(drdy_b), .MCU_Opcode_InBUS(op_b), .MCU_Trap_Clear(clr_b),
        .MCU_Internal_State(st_b), .MCU_Pc_Reset(pcr_b), .MCU_Enpc_Set(eps_b),
        .MCU_Enpc_Reset(epr_b), .MCU_Ir_Reset(irr_b), .MCU_Ir_Set(irs_b),
        .MCU_RegFile_Reset(rfr_b), .MCU_Insmem_Ready(insr_b),
        .MCU_Datamem_Ready_Out(dro_b), .MCU_Datamem_Valid_Out(dvo_b),
        .MCU_Trap(trap_b), .MCU_Trap_Cause(cause_b), .MCU_Retired(ret_b)
    );

    // Control bundle per state: {pc_rst, enpc_set, enpc_rst, ir_rst, ir_set, rf_rst, ins_rdy, dm_rdy_out, dm_vld_out, trap}
    function automatic logic [9:0] exp_ctrl(input logic [2:0] st);
        case (st)
            WT:      return 10'b0010001000;
            FE:      return 10'b0010100000;
            EX:      return 10'b0110000000;
            WV:      return 10'b0000000100;
            WR:      return 10'b0000000010;
            TR:      return 10'b0000000001;
            default: return 10'b1001010000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [2:0] st, input logic [1:0] cause, input logic [3:0] ret,
                                input logic insv, input logic [6:0] op, input logic dval,
                                input logic drdy, input logic clr);
        vec_t v;
        v.st = st; v.cause = cause; v.ret = ret; v.insv = insv;
        v.op = op; v.dval = dval; v.drdy = drdy; v.clr = clr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   bad;

        rst_a = 1'b0; insv_a = 1'b0; dval_a = 1'b0; drdy_a = 1'b0; clr_a = 1'b0; op_a = '0;
        rst_b = 1'b0; insv_b = 1'b0; dval_b = 1'b0; drdy_b = 1'b0; clr_b = 1'b0; op_b = '0;

        //            st  cs ret insv op      dval drdy clr
        tbl.push_back(mk(RST, 0, 0, 1, OP_ALU, 0, 0, 0));
        tbl.push_back(mk(WT,  0, 0, 1, OP_ALU, 0, 0, 1));
        tbl.push_back(mk(FE,  0, 0, 1, OP_ALU, 0, 0, 0));
        tbl.push_back(mk(EX,  0, 0, 0, OP_ALU, 0, 0, 0));
        tbl.push_back(mk(WT,  0, 1, 1, OP_LD,  0, 0, 0));
        tbl.push_back(mk(FE,  0, 1, 0, OP_LD,  0, 0, 0));
        tbl.push_back(mk(WV,  0, 1, 0, OP_LD,  0, 0, 0));
        tbl.push_back(mk(WV,  0, 1, 0, OP_LD,  0, 0, 1));
        tbl.push_back(mk(WV,  0, 1, 0, OP_LD,  1, 0, 0));
        tbl.push_back(mk(EX,  0, 1, 0, OP_LD,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 2, 1, OP_ST,  0, 0, 0));
        tbl.push_back(mk(FE,  0, 2, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 2, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 2, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 2, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 2, 0, OP_ST,  0, 1, 0));
        tbl.push_back(mk(EX,  0, 2, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(TR,  2, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(TR,  2, 3, 0, OP_ST,  0, 0, 1));
        tbl.push_back(mk(RST, 0, 3, 1, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 1, OP_ST,  0, 0, 0));
        tbl.push_back(mk(FE,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(WR,  0, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(TR,  3, 3, 0, OP_ST,  0, 0, 0));
        tbl.push_back(mk(TR,  3, 3, 0, OP_ST,  0, 0, 1));
        tbl.push_back(mk(RST, 0, 3, 1, OP_BAD, 0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 1, OP_BAD, 0, 0, 0));
        tbl.push_back(mk(FE,  0, 3, 0, OP_BAD, 0, 0, 0));
        tbl.push_back(mk(TR,  1, 3, 0, OP_BAD, 0, 0, 1));
        tbl.push_back(mk(RST, 0, 3, 1, OP_JAL, 0, 0, 0));
        tbl.push_back(mk(WT,  0, 3, 1, OP_JAL, 0, 0, 0));
        tbl.push_back(mk(FE,  0, 3, 0, OP_JAL, 0, 0, 0));
        tbl.push_back(mk(EX,  0, 3, 0, OP_JAL, 0, 0, 0));
        tbl.push_back(mk(WT,  0, 4, 0, OP_JAL, 0, 0, 0));

        // Reset state while MCU_Reset is held low
        #2;
        check("a_rst_state",  st_a,    RST);
        check("a_rst_ctrl",   ctrl_a,  exp_ctrl(RST));
        check("a_rst_cause",  cause_a, 0);
        check("a_rst_retired", ret_a,  0);
        check("b_rst_state",  st_b,    RST);
        check("b_rst_retired", ret_b,  0);

        @(negedge clk);
        rst_a = 1'b1;

        foreach (tbl[i]) begin
            insv_a = tbl[i].insv; op_a = tbl[i].op; dval_a = tbl[i].dval;
            drdy_a = tbl[i].drdy; clr_a = tbl[i].clr;
            check($sformatf("row%0d_state", i),   st_a,    tbl[i].st);
            check($sformatf("row%0d_ctrl", i),    ctrl_a,  exp_ctrl(tbl[i].st));
            check($sformatf("row%0d_cause", i),   cause_a, tbl[i].cause);
            check($sformatf("row%0d_retired", i), ret_a,   tbl[i].ret);
            tick();
        end
        insv_a = 1'b0; clr_a = 1'b0;

        // Retired wraps modulo 16: currently 4, run 11 ALU instructions to 15, one more to 0
        for (int k = 0; k < 12; k++) begin
            insv_a = 1'b1; op_a = OP_ALU;
            tick();
            insv_a = 1'b0;
            tick();
            tick();
            if (k == 10) check("wrap_retired_15", ret_a, 15);
        end
        check("wrap_retired_0", ret_a, 0);
        check("wrap_state", st_a, WT);

        // Async reset in the middle of a load wait
        insv_a = 1'b1; op_a = OP_LD;
        tick();
        insv_a = 1'b0;
        tick();
        check("midrst_pre_state", st_a, WV);
        check("midrst_pre_rdy", dro_a, 1);
        #1 rst_a = 1'b0;
        #1;
        check("midrst_state", st_a, RST);
        check("midrst_rdy", dro_a, 0);
        check("midrst_ctrl", ctrl_a, exp_ctrl(RST));
        check("midrst_retired", ret_a, 0);
        @(negedge clk);
        rst_a = 1'b1;
        tick();
        check("midrst_release_state", st_a, WT);

        // Instance B: no timeout, idle 1000 cycles in WAIT
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check("b_wait_state", st_b, WT);
        bad = 0;
        repeat (1000) begin
            tick();
            if (st_b !== WT || trap_b !== 1'b0) bad++;
        end
        check("b_idle_bad_cycles", bad, 0);
        check("b_idle_trap", trap_b, 0);

        // Unknown opcode executes when illegal checking is off
        insv_b = 1'b1; op_b = OP_BAD;
        tick();
        insv_b = 1'b0;
        tick();
        check("b_bad_state", st_b, EX);
        check("b_bad_ctrl", ctrl_b, exp_ctrl(EX));
        tick();
        check("b_bad_retired", ret_b, 1);
        check("b_bad_cause", cause_b, 0);

        // Long load wait never times out
        insv_b = 1'b1; op_b = OP_LD;
        tick();
        insv_b = 1'b0;
        repeat (300) tick();
        check("b_long_wait_state", st_b, WV);
        dval_b = 1'b1;
        tick();
        dval_b = 1'b0;
        check("b_long_exec_state", st_b, EX);
        tick();
        check("b_long_retired", ret_b, 2);
        check("b_long_state", st_b, WT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
